// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encoding, opcode classes and flag indices for the cpu sequencer
package cpu_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_BRC = 4'hB;
  localparam logic [3:0] OP_BRN = 4'hC;
  localparam logic [3:0] OP_BRZ = 4'hD;
  localparam logic [3:0] OP_BR = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_C = 0;
  function automatic logic is_alu(input logic [3:0] c);
    return c != OP_NOP && c < OP_BRC;
  endfunction
endpackage

// File: rtl/seq_branch_eval.sv
// seq_branch_eval: branch-taken decision from opcode class and ZNC flags
module seq_branch_eval
  import cpu_seq_pkg::*;
(
  input  logic [3:0] cls,
  input  logic [2:0] znc,
  output logic       take
);
  assign take = cls == OP_BRC ? znc[F_C] :
                cls == OP_BRN ? znc[F_N] :
                cls == OP_BRZ ? znc[F_Z] : cls == OP_BR;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/wb control FSM, single-step under CPU_SEQ_STEP_EN
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_req,
  input  logic [15:0]      opCode,
  input  logic [2:0]       ZNC_out,
  output logic             fetch_en,
  output logic             BR,
  output logic             A_we,
  output logic             B_we,
  output logic             ZNC_we,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] instr_count
);
`ifdef CPU_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  state_t state;
  logic br_pending, stepping, take, go_step, alu, unused_op;
  logic [3:0] cls, wait_cnt;
  assign cls = opCode[15:12];
  assign alu = is_alu(cls);
  assign go_step = STEP_EN && !run && step_req;
  assign unused_op = ^opCode[10:0];
  seq_branch_eval u_branch (.cls(cls), .znc(ZNC_out), .take(take));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      fetch_en <= 1'b0;
      BR <= 1'b0;
      A_we <= 1'b0;
      B_we <= 1'b0;
      ZNC_we <= 1'b0;
      halted <= 1'b0;
      step_ack <= 1'b0;
      instr_count <= '0;
      br_pending <= 1'b0;
      stepping <= 1'b0;
      wait_cnt <= '0;
    end else begin
      fetch_en <= 1'b0;
      BR <= 1'b0;
      A_we <= 1'b0;
      B_we <= 1'b0;
      ZNC_we <= 1'b0;
      step_ack <= 1'b0;
      case (state)
        S_IDLE: if (run || go_step) begin
          state <= S_FETCH;
          fetch_en <= 1'b1;
          BR <= br_pending;
          br_pending <= 1'b0;
          stepping <= go_step;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: if (cls == OP_HALT) begin
          state <= S_HALT;
          halted <= 1'b1;
          instr_count <= instr_count + CNT_W'(1);
        end else begin
          state <= S_EXEC;
          wait_cnt <= 4'(EXEC_CYCLES - 1);
        end
        S_EXEC: if (wait_cnt == 4'd0) begin
          state <= S_WB;
          A_we <= alu && !opCode[11];
          B_we <= alu && opCode[11];
          ZNC_we <= alu;
          step_ack <= stepping;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        S_WB: begin
          instr_count <= instr_count + CNT_W'(1);
          stepping <= 1'b0;
          if (run && !stepping) begin
            state <= S_FETCH;
            fetch_en <= 1'b1;
            BR <= take;
            br_pending <= 1'b0;
          end else begin
            state <= S_IDLE;
            br_pending <= take;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed table and corner-sequence bench for cpu_sequencer
module tb_cpu_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, run, step_req, fe, br, a_we, b_we, z_we, halted, step_ack;
  logic [15:0] op, cnt;
  logic [2:0] znc;
  logic rst2, run2, fe2, br2, a_we2, b_we2, z_we2, halted2, step_ack2;
  logic [15:0] op2;
  logic [2:0] znc2;
  logic [3:0] cnt2;
  logic zero = 1'b0;
  int n_chk = 0, n_fail = 0;
  cpu_sequencer #(.EXEC_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req), .opCode(op), .ZNC_out(znc),
    .fetch_en(fe), .BR(br), .A_we(a_we), .B_we(b_we), .ZNC_we(z_we), .halted(halted),
    .step_ack(step_ack), .instr_count(cnt));
  cpu_sequencer #(.EXEC_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst2), .run(run2), .step_req(zero), .opCode(op2), .ZNC_out(znc2),
    .fetch_en(fe2), .BR(br2), .A_we(a_we2), .B_we(b_we2), .ZNC_we(z_we2), .halted(halted2),
    .step_ack(step_ack2), .instr_count(cnt2));
  typedef struct {
    logic [15:0] op;
    logic [2:0]  znc;
    logic        a, b, z, br;
  } vec_t;
  vec_t vt[14];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1; run = 1'b0; step_req = 1'b0;
    rst2 = 1'b1; run2 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    rst2 = 1'b0;
  endtask
  task automatic wait_fetch(input bit second);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick;
      ok = second ? fe2 : fe;
    end
    chk("fetch_seen", 32'(ok), 1);
  endtask
  initial begin
    int n_fe, n_we, n_ack, n_a;
    vt[0]  = '{16'h1000, 3'b000, 1, 0, 1, 0};
    vt[1]  = '{16'h1800, 3'b000, 0, 1, 1, 0};
    vt[2]  = '{16'h7A55, 3'b111, 0, 1, 1, 0};
    vt[3]  = '{16'h2345, 3'b010, 1, 0, 1, 0};
    vt[4]  = '{16'hA800, 3'b000, 0, 1, 1, 0};
    vt[5]  = '{16'h0000, 3'b111, 0, 0, 0, 0};
    vt[6]  = '{16'hD000, 3'b100, 0, 0, 0, 1};
    vt[7]  = '{16'hD000, 3'b000, 0, 0, 0, 0};
    vt[8]  = '{16'hE000, 3'b000, 0, 0, 0, 1};
    vt[9]  = '{16'hE000, 3'b111, 0, 0, 0, 1};
    vt[10] = '{16'hB000, 3'b001, 0, 0, 0, 1};
    vt[11] = '{16'hB000, 3'b110, 0, 0, 0, 0};
    vt[12] = '{16'hC000, 3'b010, 0, 0, 0, 1};
    vt[13] = '{16'hC000, 3'b101, 0, 0, 0, 0};
    op = 16'h0; znc = 3'b000; op2 = 16'h0; znc2 = 3'b000;
    rst = 1'b1; run = 1'b1; step_req = 1'b0; rst2 = 1'b1; run2 = 1'b0;
    tick;
    chk("reset_outputs", {fe, br, a_we, b_we, z_we, halted, step_ack}, 0);
    chk("reset_count", cnt, 0);
    for (int i = 0; i < 14; i++) begin
      do_reset;
      op = vt[i].op; znc = vt[i].znc; run = 1'b1;
      wait_fetch(0);
      chk("first_br", br, 0);
      tick;
      chk("we_quiet_decode", {a_we, b_we, z_we}, 0);
      tick;
      chk("we_quiet_exec", {a_we, b_we, z_we}, 0);
      tick;
      chk("wb_a_we", a_we, vt[i].a);
      chk("wb_b_we", b_we, vt[i].b);
      chk("wb_znc_we", z_we, vt[i].z);
      chk("wb_no_fetch", fe, 0);
      tick;
      chk("next_fetch", fe, 1);
      chk("next_br", br, vt[i].br);
      chk("count_one", cnt, 1);
      chk("we_cleared", {a_we, b_we, z_we}, 0);
    end
    do_reset;
    op = 16'hD000; znc = 3'b100; run = 1'b1;
    wait_fetch(0);
    run = 1'b0;
    n_fe = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_fe += int'(fe);
    end
    chk("idle_no_fetch", n_fe, 0);
    chk("idle_count", cnt, 1);
    znc = 3'b000;
    run = 1'b1;
    wait_fetch(0);
    chk("resumed_br", br, 1);
    do_reset;
    op = 16'hF000; run = 1'b1;
    wait_fetch(0);
    tick;
    chk("halt_not_yet", halted, 0);
    tick;
    chk("halted", halted, 1);
    chk("halt_count", cnt, 1);
    n_fe = 0; n_we = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_fe += int'(fe);
      n_we += int'(a_we | b_we | z_we);
    end
    chk("halt_no_fetch", n_fe, 0);
    chk("halt_no_we", n_we, 0);
    chk("halt_held", halted, 1);
    rst = 1'b1; run = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("halt_rst", halted, 0);
    chk("halt_rst_fetch", fe, 0);
    do_reset;
    op = 16'h1000; run = 1'b1;
    wait_fetch(0);
    for (int i = 0; i < 4; i++) tick;
    chk("pre_abort_fetch", fe, 1);
    chk("pre_abort_count", cnt, 1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("abort_outputs", {fe, br, a_we, b_we, z_we, halted, step_ack}, 0);
    chk("abort_count", cnt, 0);
    rst = 1'b0; run = 1'b0;
    tick;
    chk("abort_no_we", {a_we, b_we, z_we}, 0);
    do_reset;
    op2 = 16'h1000; run2 = 1'b1;
    wait_fetch(1);
    tick;
    tick;
    run2 = 1'b0;
    tick;
    tick;
    tick;
    chk("exec4_quiet", {a_we2, b_we2, z_we2}, 0);
    tick;
    chk("exec4_wb", {a_we2, b_we2, z_we2}, 3'b101);
    n_fe = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_fe += int'(fe2);
    end
    chk("exec4_no_fetch", n_fe, 0);
    chk("exec4_count", cnt2, 1);
    do_reset;
    op2 = 16'h0000; run2 = 1'b1;
    n_fe = 0;
    for (int i = 0; i < 400 && n_fe < 17; i++) begin
      tick;
      n_fe += int'(fe2);
      if (fe2 && n_fe == 16) chk("wrap_pre", cnt2, 15);
    end
    chk("wrap_fetches", n_fe, 17);
    chk("wrap_zero", cnt2, 0);
    run2 = 1'b0;
    do_reset;
    op = 16'h1000; znc = 3'b000;
    n_fe = 0; n_ack = 0; n_a = 0;
    step_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      step_req = 1'b0;
      n_fe += int'(fe);
      n_ack += int'(step_ack);
      n_a += int'(a_we);
      if (step_ack) chk("ack_with_we", a_we, 1);
    end
`ifdef CPU_SEQ_STEP_EN
    chk("step_fetch", n_fe, 1);
    chk("step_ack", n_ack, 1);
    chk("step_we", n_a, 1);
    chk("step_count", cnt, 1);
`else
    chk("step_fetch", n_fe, 0);
    chk("step_ack", n_ack, 0);
    chk("step_we", n_a, 0);
    chk("step_count", cnt, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
